// File: rtl/mcs4_clockgen_step_if.sv
// Control and clock bundle between the clock generator and its controller.
// Registered outputs with no backpressure; inputs are sampled on each sysclk.
interface mcs4_clockgen_step_if #(parameter int CNT_W = 16);
    logic             run;
    logic             step;
    logic             sync;
    logic             clk1;
    logic             clk2;
    logic             halted;
    logic             step_done;
    logic [CNT_W-1:0] period_count;

    modport master (
        output run, step, sync,
        input  clk1, clk2, halted, step_done, period_count
    );

    modport slave (
        input  run, step, sync,
        output clk1, clk2, halted, step_done, period_count
    );
endinterface

// File: rtl/mcs4_clockgen_step.sv
// Two-phase non-overlapping MCS-4 clock generator with run/halt/single-step at sync boundaries.
// clk1/clk2 are registered from the next state; no backpressure, restart one sysclk after run/step.
module mcs4_clockgen_step #(
    parameter int SYSCLK_TCY = 50,
    parameter int PHI1_NS    = 400,
    parameter int D1_NS      = 150,
    parameter int PHI2_NS    = 400,
    parameter int TCY_NS     = 1350,
    parameter int CNT_W      = 16
) (
    input  logic                  sysclk,
    input  logic                  reset,
    mcs4_clockgen_step_if.slave   bus
);
    localparam int GAP_NS = TCY_NS - PHI1_NS - D1_NS - PHI2_NS;
    localparam int N1  = (PHI1_NS / SYSCLK_TCY < 1) ? 1 : PHI1_NS / SYSCLK_TCY;
    localparam int ND1 = (D1_NS   / SYSCLK_TCY < 1) ? 1 : D1_NS   / SYSCLK_TCY;
    localparam int N2  = (PHI2_NS / SYSCLK_TCY < 1) ? 1 : PHI2_NS / SYSCLK_TCY;
    localparam int ND2 = (GAP_NS  / SYSCLK_TCY < 1) ? 1 : GAP_NS  / SYSCLK_TCY;

    typedef enum logic [2:0] {PHI1, GAP1, PHI2, GAP2, STOP} phase_t;
    typedef enum logic {MODE_RUN, MODE_STEP} mode_t;

    phase_t           state, state_n;
    mode_t            mode, mode_n;
    logic [15:0]      cnt, cnt_n;
    logic             seen, seen_n;
    logic             primed, primed_n;
    logic             halted_q, halted_n;
    logic             done_q, done_n;
    logic             inc;
    logic             clk1_q, clk2_q;
    logic [CNT_W-1:0] count;

    always_comb begin
        state_n  = state;
        mode_n   = mode;
        cnt_n    = cnt - 16'd1;
        seen_n   = seen;
        primed_n = primed;
        halted_n = halted_q;
        done_n   = 1'b0;
        inc      = 1'b0;
        if (state == PHI2 && bus.sync)
            seen_n = 1'b1;
        case (state)
            PHI1: if (cnt == 16'd0) begin
                state_n = GAP1;
                cnt_n   = 16'(ND1 - 1);
            end
            GAP1: if (cnt == 16'd0) begin
                state_n = PHI2;
                cnt_n   = 16'(N2 - 1);
            end
            PHI2: if (cnt == 16'd0) begin
                state_n = GAP2;
                cnt_n   = 16'(ND2 - 1);
            end
            GAP2: if (cnt == 16'd0) begin
                // The gap left by reset is not a completed period.
                inc      = primed;
                primed_n = 1'b1;
                if (seen && !bus.run) begin
                    state_n  = STOP;
                    cnt_n    = cnt;
                    halted_n = 1'b1;
                    done_n   = (mode == MODE_STEP);
                    mode_n   = MODE_RUN;
                end else begin
                    state_n = PHI1;
                    cnt_n   = 16'(N1 - 1);
                    seen_n  = 1'b0;
                    if (seen)
                        mode_n = MODE_RUN;
                end
            end
            STOP: begin
                cnt_n = cnt;
                if (bus.run || bus.step) begin
                    state_n  = PHI1;
                    cnt_n    = 16'(N1 - 1);
                    seen_n   = 1'b0;
                    halted_n = 1'b0;
                    mode_n   = bus.run ? MODE_RUN : MODE_STEP;
                end
            end
            default: begin
                state_n = GAP2;
                cnt_n   = 16'(ND2 - 1);
            end
        endcase
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state    <= GAP2;
            mode     <= MODE_RUN;
            cnt      <= 16'(ND2 - 1);
            seen     <= 1'b0;
            primed   <= 1'b0;
            halted_q <= 1'b0;
            done_q   <= 1'b0;
            clk1_q   <= 1'b0;
            clk2_q   <= 1'b0;
            count    <= '0;
        end else begin
            state    <= state_n;
            mode     <= mode_n;
            cnt      <= cnt_n;
            seen     <= seen_n;
            primed   <= primed_n;
            halted_q <= halted_n;
            done_q   <= done_n;
            clk1_q   <= (state_n == PHI1);
            clk2_q   <= (state_n == PHI2);
            if (inc)
                count <= count + 1'b1;
        end
    end

    assign bus.clk1         = clk1_q;
    assign bus.clk2         = clk2_q;
    assign bus.halted       = halted_q;
    assign bus.step_done    = done_q;
    assign bus.period_count = count;
endmodule
